// File: rtl/pe_edge_feeder_pkg.sv
// Shared PE array constants: default geometry and the edge feeder FSM encodings.
package pe_edge_feeder_pkg;

    localparam int unsigned PE_N      = 3;
    localparam int unsigned PE_IN_LEN = 8;
    localparam int unsigned PE_K_MAX  = 8;

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_FEED  = 2'd1;
    localparam logic [ST_W-1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/skew_delay_line.sv
// Zero-reset shift register of DEPTH stages; DEPTH=0 degenerates to a wire.
module skew_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst};
        assign q = d;
    end else begin : g_pipe
        logic [W-1:0] pipe [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < int'(DEPTH); k++) pipe[k] <= '0;
            end else begin
                pipe[0] <= d;
                for (int k = 1; k < int'(DEPTH); k++) pipe[k] <= pipe[k-1];
            end
        end

        assign q = pipe[DEPTH-1];
    end

endmodule

// File: rtl/pe_edge_feeder.sv
// Buffers an N x K operand tile and streams it onto one systolic array edge with
// per-lane diagonal skew, plus the corner-PE cal_en / cal_done handshake.
module pe_edge_feeder
    import pe_edge_feeder_pkg::*;
#(
    parameter int unsigned N      = PE_N,
    parameter int unsigned IN_LEN = PE_IN_LEN,
    parameter int unsigned K_MAX  = PE_K_MAX,
    localparam int unsigned LANE_W = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned COL_W  = (K_MAX > 1) ? $clog2(K_MAX) : 1,
    localparam int unsigned KL_W   = $clog2(K_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic                  wr_en,
    input  logic [LANE_W-1:0]     wr_lane,
    input  logic [COL_W-1:0]      wr_col,
    input  logic [IN_LEN-1:0]     wr_data,
    output logic                  wr_err,
    input  logic                  start,
    input  logic [KL_W-1:0]       k_len,
    output logic                  busy,
    output logic [N*IN_LEN-1:0]   edge_bus,
    output logic                  cal_en,
    output logic                  cal_done
);

    localparam int unsigned DRN_W = LANE_W;

    logic [IN_LEN-1:0]          tile [N][K_MAX];
    logic [ST_W-1:0]            state_q, state_d;
    logic [COL_W-1:0]           col_q, col_d;
    logic [DRN_W-1:0]           drn_q, drn_d;
    logic [KL_W-1:0]            klen_q, klen_d;
    logic [N-1:0][IN_LEN-1:0]   lane_q, lane_d;
    logic                       cal_done_d;
    logic                       wr_ok;
    logic                       go;
    logic [KL_W-1:0]            klen_clamp;
    logic [KL_W-1:0]            col_nxt;

    assign wr_ok = wr_en && !busy
                && ({1'b0, wr_lane} < (LANE_W+1)'(N))
                && ({1'b0, wr_col}  < (COL_W+1)'(K_MAX));

    assign klen_clamp = (k_len > KL_W'(K_MAX)) ? KL_W'(K_MAX) : k_len;
    assign go         = (state_q == ST_IDLE) && start && (k_len != '0);
    assign col_nxt    = KL_W'(col_q) + KL_W'(1);

    // Operand tile; never reset, only written by in-range writes while idle.
    always_ff @(posedge clk) begin
        if (wr_ok) tile[wr_lane][wr_col] <= wr_data;
    end

    // Next-state logic; lane_d is the unskewed value each lane shows next cycle.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        drn_d      = drn_q;
        klen_d     = klen_q;
        lane_d     = '0;
        cal_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_FEED;
                    col_d   = '0;
                    klen_d  = klen_clamp;
                    // A write in the start cycle must reach the first column.
                    for (int i = 0; i < int'(N); i++) begin
                        lane_d[i] = (wr_ok && wr_lane == LANE_W'(i) && wr_col == '0)
                                  ? wr_data : tile[i][0];
                    end
                end
            end
            ST_FEED: begin
                if (col_nxt == klen_q) begin
                    cal_done_d = 1'b1;
                    drn_d      = '0;
                    state_d    = (N > 1) ? ST_DRAIN : ST_IDLE;
                end else begin
                    col_d = (col_q == COL_W'(K_MAX - 1)) ? col_q : col_q + COL_W'(1);
                    for (int i = 0; i < int'(N); i++) begin
                        lane_d[i] = tile[i][COL_W'(col_nxt)];
                    end
                end
            end
            ST_DRAIN: begin
                if (drn_q == DRN_W'(N - 2)) state_d = ST_IDLE;
                else                        drn_d   = drn_q + DRN_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            drn_q    <= '0;
            klen_q   <= '0;
            lane_q   <= '0;
            cal_en   <= 1'b0;
            cal_done <= 1'b0;
            busy     <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            drn_q    <= drn_d;
            klen_q   <= klen_d;
            lane_q   <= lane_d;
            cal_en   <= (state_d == ST_FEED);
            cal_done <= cal_done_d;
            busy     <= (state_d != ST_IDLE);
            wr_err   <= wr_en && !wr_ok;
        end
    end

    // Lane i trails lane 0 by i cycles to form the systolic wavefront.
    for (genvar gi = 0; gi < int'(N); gi++) begin : g_lane
        skew_delay_line #(
            .DEPTH (gi),
            .W     (IN_LEN)
        ) u_skew (
            .clk (clk),
            .rst (sys_rst),
            .d   (lane_q[gi]),
            .q   (edge_bus[gi*IN_LEN +: IN_LEN])
        );
    end

endmodule

// File: tb/tb_pe_edge_feeder.sv
// Directed bench for pe_edge_feeder (N=3, IN_LEN=8, K_MAX=8) with a hand-kept tile model.
module tb_pe_edge_feeder;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        wr_en;
    logic [1:0]  wr_lane;
    logic [2:0]  wr_col;
    logic [7:0]  wr_data;
    logic        wr_err;
    logic        start;
    logic [3:0]  k_len;
    logic        busy;
    logic [23:0] edge_bus;
    logic        cal_en;
    logic        cal_done;

    int n_cmp = 0;
    int n_bad = 0;
    bit watch = 1'b0;

    logic [7:0] m [3][8];

    always #5 clk = ~clk;

    pe_edge_feeder dut (
        .clk      (clk),
        .sys_rst  (sys_rst),
        .wr_en    (wr_en),
        .wr_lane  (wr_lane),
        .wr_col   (wr_col),
        .wr_data  (wr_data),
        .wr_err   (wr_err),
        .start    (start),
        .k_len    (k_len),
        .busy     (busy),
        .edge_bus (edge_bus),
        .cal_en   (cal_en),
        .cal_done (cal_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // cal_done marks the cycle after cal_en falls, so both high is illegal.
    always @(negedge clk) begin
        if (watch) begin
            n_cmp++;
            assert (!(cal_en === 1'b1 && cal_done === 1'b1)) else begin
                n_bad++;
                $error("FAIL cal_overlap: observed cal_en=%b cal_done=%b expected not both 1",
                       cal_en, cal_done);
            end
        end
    end

    function automatic logic [23:0] exp_bus(input int c, input int k);
        logic [23:0] b;
        b = '0;
        for (int i = 0; i < 3; i++) begin
            int j;
            j = c - 1 - i;
            if (j >= 0 && j < k) b[i*8 +: 8] = m[i][j];
        end
        return b;
    endfunction

    task automatic check_cycle(input int c, input int k, input string nm);
        chk($sformatf("%s bus c%0d", nm, c), 32'(edge_bus), 32'(exp_bus(c, k)));
        chk($sformatf("%s cal_en c%0d", nm, c), 32'(cal_en), 32'(c <= k));
        chk($sformatf("%s cal_done c%0d", nm, c), 32'(cal_done), 32'(c == k + 1));
        chk($sformatf("%s busy c%0d", nm, c), 32'(busy), 32'(c <= k + 2));
    endtask

    task automatic check_idle(input string nm);
        chk({nm, " bus"}, 32'(edge_bus), 32'd0);
        chk({nm, " cal_en"}, 32'(cal_en), 32'd0);
        chk({nm, " cal_done"}, 32'(cal_done), 32'd0);
        chk({nm, " busy"}, 32'(busy), 32'd0);
    endtask

    task automatic wr(input int lane, input int col, input logic [7:0] data);
        wr_en = 1'b1; wr_lane = 2'(lane); wr_col = 3'(col); wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        chk($sformatf("wr_err ok l%0d c%0d", lane, col), 32'(wr_err), 32'd0);
    endtask

    task automatic play(input int kin, input int kexp, input int ncyc, input string nm);
        start = 1'b1; k_len = 4'(kin);
        @(negedge clk);
        start = 1'b0; k_len = '0;
        for (int c = 1; c <= ncyc; c++) begin
            check_cycle(c, kexp, nm);
            @(negedge clk);
        end
    endtask

    initial begin
        sys_rst = 1'b1; wr_en = 1'b0; wr_lane = '0; wr_col = '0; wr_data = '0;
        start = 1'b0; k_len = '0;
        @(negedge clk);
        @(negedge clk);
        check_idle("in_reset");
        sys_rst = 1'b0;
        watch = 1'b1;

        // Reset then idle
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_idle($sformatf("idle%0d", c));
            chk($sformatf("idle%0d wr_err", c), 32'(wr_err), 32'd0);
        end

        // Load the full tile: row0 2..9, row1 5..12, row2 1,1,1 then 0x13..
        for (int j = 0; j < 8; j++) begin
            m[0][j] = 8'(j + 2);
            m[1][j] = 8'(j + 5);
            m[2][j] = (j < 3) ? 8'd1 : 8'(j + 16);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 8; j++)
                wr(i, j, m[i][j]);

        // Basic skewed stream, k_len=3
        play(3, 3, 7, "s2");

        // k_len=0 is ignored
        start = 1'b1; k_len = 4'd0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check_idle($sformatf("k0 c%0d", c));
            @(negedge clk);
        end

        // k_len=12 clamps to 8
        play(12, 8, 11, "clamp");

        // Same-cycle write and start with k_len=1
        wr_en = 1'b1; wr_lane = 2'd0; wr_col = 3'd0; wr_data = 8'd9;
        start = 1'b1; k_len = 4'd1;
        m[0][0] = 8'd9;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0; k_len = '0;
        chk("s5 wr_err", 32'(wr_err), 32'd0);
        for (int c = 1; c <= 4; c++) begin
            check_cycle(c, 1, "s5");
            @(negedge clk);
        end
        m[0][0] = 8'd2;
        wr(0, 0, 8'd2);

        // Out-of-range lane write while idle
        wr_en = 1'b1; wr_lane = 2'd3; wr_col = 3'd0; wr_data = 8'h55;
        @(negedge clk);
        wr_en = 1'b0;
        chk("s4 wr_err lane3", 32'(wr_err), 32'd1);
        @(negedge clk);
        chk("s4 wr_err clear", 32'(wr_err), 32'd0);

        // Write and second start while busy are both dropped
        start = 1'b1; k_len = 4'd2;
        @(negedge clk);
        check_cycle(1, 2, "s4");
        wr_en = 1'b1; wr_lane = 2'd0; wr_col = 3'd0; wr_data = 8'hEE;
        start = 1'b1; k_len = 4'd5;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0; k_len = '0;
        chk("s4 wr_err busy", 32'(wr_err), 32'd1);
        for (int c = 2; c <= 5; c++) begin
            check_cycle(c, 2, "s4");
            @(negedge clk);
        end

        // Reset mid-stream at T+3
        start = 1'b1; k_len = 4'd3;
        @(negedge clk);
        start = 1'b0; k_len = '0;
        for (int c = 1; c <= 3; c++) begin
            check_cycle(c, 3, "s6pre");
            if (c == 3) sys_rst = 1'b1;
            @(negedge clk);
        end
        sys_rst = 1'b0;
        for (int c = 4; c <= 7; c++) begin
            check_idle($sformatf("s6rst c%0d", c));
            @(negedge clk);
        end

        // Restart reproduces the original stream from stored data
        play(3, 3, 7, "s6post");

        watch = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
